// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR = 6'b100110;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ADD_OP   = 2'd0,
        SUB_OP   = 2'd1,
        FUNCT_OP = 2'd2
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU intent plus the funct field onto the alu op code.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t              alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output alu_ctrl_t            alu_control,
    output logic                 funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        unique case (alu_op)
            ADD_OP: alu_control = ALU_ADD;
            SUB_OP: alu_control = ALU_SUB;
            FUNCT_OP: begin
                unique case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_XOR: alu_control = ALU_XOR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle datapath; drives alu and all enables/selects.
module mc_controller
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    output logic                 pc_en,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [ALUC_W-1:0]    alu_control,
    output logic                 illegal
);

    state_t    state;
    alu_op_t   alu_op;
    alu_ctrl_t alu_ctrl;
    logic      funct_illegal;
    logic      pc_write;
    logic      branch;

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (alu_ctrl),
        .funct_illegal (funct_illegal)
    );

    // State register and next-state sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            unique case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    unique case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEXEC;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: begin
                    if (op == OP_LW)      state <= MEMREAD;
                    else if (op == OP_SW) state <= MEMWRITE;
                    else                  state <= FETCH;
                end
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECUTE:  state <= funct_illegal ? FETCH : ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                ADDIEXEC: state <= ADDIWB;
                ADDIWB:   state <= FETCH;
                JUMP:     state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    // ALU intent depends on state only, kept apart from the output decode.
    always_comb begin
        alu_op = ADD_OP;
        unique case (state)
            EXECUTE: alu_op = FUNCT_OP;
            BRANCH:  alu_op = SUB_OP;
            default: alu_op = ADD_OP;
        endcase
    end

    // Moore output decode; a high reset overrides everything in the same cycle.
    always_comb begin
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        alu_control = ALUC_W'(alu_ctrl);

        unique case (state)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                unique case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMREAD: iord = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                illegal   = funct_illegal;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                alu_control = ALUC_W'(ALU_ADD);
            end
        endcase

        if (reset) begin
            iord        = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            pc_src      = 2'b00;
            pc_write    = 1'b0;
            branch      = 1'b0;
            illegal     = 1'b0;
            alu_control = ALUC_W'(ALU_ADD);
        end
    end

    assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle check of mc_controller outputs against hand-built vectors.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    wire [15:0] outv = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                        alu_src_a, alu_src_b, pc_src, alu_control, illegal};

    // Packs {pc_en,iord,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,src_a,src_b,pc_src,aluc,illegal}.
    function automatic logic [15:0] mk(input int pe, input int io, input int mw, input int irw,
                                       input int rw, input int rd, input int m2r, input int sa,
                                       input int sb, input int ps, input int ac, input int il);
        return {1'(pe), 1'(io), 1'(mw), 1'(irw), 1'(rw), 1'(rd), 1'(m2r), 1'(sa),
                2'(sb), 2'(ps), 3'(ac), 1'(il)};
    endfunction

    logic [15:0] V_RST, V_FETCH, V_DECODE, V_DECODE_ILL, V_MEMADR, V_MEMREAD, V_MEMWB;
    logic [15:0] V_MEMWRITE, V_ALUWB, V_BR_Z1, V_BR_Z0, V_ADDIEXEC, V_ADDIWB, V_JUMP, V_EXEC_ILL;

    task automatic chk(input string tag, input logic [15:0] exp);
        total++;
        assert (outv === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, outv, exp);
        end
    endtask

    task automatic at_cycle(input string tag, input logic [15:0] exp);
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    logic [5:0] rfunct [6];
    int         rcode  [6];

    initial begin
        V_RST        = mk(0,0,0,0,0,0,0,0,0,0,0,0);
        V_FETCH      = mk(1,0,0,1,0,0,0,0,1,0,0,0);
        V_DECODE     = mk(0,0,0,0,0,0,0,0,3,0,0,0);
        V_DECODE_ILL = mk(0,0,0,0,0,0,0,0,3,0,0,1);
        V_MEMADR     = mk(0,0,0,0,0,0,0,1,2,0,0,0);
        V_MEMREAD    = mk(0,1,0,0,0,0,0,0,0,0,0,0);
        V_MEMWB      = mk(0,0,0,0,1,0,1,0,0,0,0,0);
        V_MEMWRITE   = mk(0,1,1,0,0,0,0,0,0,0,0,0);
        V_ALUWB      = mk(0,0,0,0,1,1,0,0,0,0,0,0);
        V_BR_Z1      = mk(1,0,0,0,0,0,0,1,0,1,1,0);
        V_BR_Z0      = mk(0,0,0,0,0,0,0,1,0,1,1,0);
        V_ADDIEXEC   = mk(0,0,0,0,0,0,0,1,2,0,0,0);
        V_ADDIWB     = mk(0,0,0,0,1,0,0,0,0,0,0,0);
        V_JUMP       = mk(1,0,0,0,0,0,0,0,0,2,0,0);
        V_EXEC_ILL   = mk(0,0,0,0,0,0,0,1,0,0,0,1);

        rfunct[0] = 6'b101010; rcode[0] = 5;
        rfunct[1] = 6'b100000; rcode[1] = 0;
        rfunct[2] = 6'b100010; rcode[2] = 1;
        rfunct[3] = 6'b100100; rcode[3] = 2;
        rfunct[4] = 6'b100101; rcode[4] = 3;
        rfunct[5] = 6'b100110; rcode[5] = 4;

        reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;

        // Reset held for three edges, outputs quiet throughout.
        repeat (3) at_cycle("reset_hold", V_RST);
        reset = 1'b0;
        #1 chk("lw_fetch", V_FETCH);
        at_cycle("lw_decode", V_DECODE);
        zero = 1'b1;
        #1 chk("lw_decode_zero1", V_DECODE);
        at_cycle("lw_memadr", V_MEMADR);
        at_cycle("lw_memread", V_MEMREAD);
        at_cycle("lw_memwb", V_MEMWB);
        zero = 1'b0;

        // R-type with every supported funct.
        for (int i = 0; i < 6; i++) begin
            at_cycle("r_fetch", V_FETCH);
            op = 6'b000000; funct = rfunct[i];
            at_cycle("r_decode", V_DECODE);
            at_cycle($sformatf("r_exec_f%0d", i), mk(0,0,0,0,0,0,0,1,0,0,rcode[i],0));
            at_cycle("r_aluwb", V_ALUWB);
        end

        // BEQ taken, then zero drops within BRANCH.
        at_cycle("beq_fetch", V_FETCH);
        op = 6'b000100;
        at_cycle("beq_decode", V_DECODE);
        zero = 1'b1;
        #1 chk("beq_decode_zero1", V_DECODE);
        at_cycle("beq_branch_z1", V_BR_Z1);
        zero = 1'b0;
        #1 chk("beq_branch_z0", V_BR_Z0);

        // BEQ not taken.
        at_cycle("beq2_fetch", V_FETCH);
        at_cycle("beq2_decode", V_DECODE);
        at_cycle("beq2_branch_z0", V_BR_Z0);

        // SW.
        at_cycle("sw_fetch", V_FETCH);
        op = 6'b101011;
        at_cycle("sw_decode", V_DECODE);
        at_cycle("sw_memadr", V_MEMADR);
        at_cycle("sw_memwrite", V_MEMWRITE);

        // J.
        at_cycle("j_fetch", V_FETCH);
        op = 6'b000010;
        at_cycle("j_decode", V_DECODE);
        at_cycle("j_jump", V_JUMP);

        // ADDI.
        at_cycle("addi_fetch", V_FETCH);
        op = 6'b001000;
        at_cycle("addi_decode", V_DECODE);
        at_cycle("addi_exec", V_ADDIEXEC);
        at_cycle("addi_wb", V_ADDIWB);

        // Unsupported opcode returns straight to FETCH.
        at_cycle("ill_fetch", V_FETCH);
        op = 6'b111111;
        at_cycle("ill_decode", V_DECODE_ILL);

        // Unsupported funct skips ALUWB.
        at_cycle("rill_fetch", V_FETCH);
        op = 6'b000000; funct = 6'b000111;
        at_cycle("rill_decode", V_DECODE);
        at_cycle("rill_exec", V_EXEC_ILL);

        // LW aborted by reset during MEMWB.
        at_cycle("lwr_fetch", V_FETCH);
        op = 6'b100011; funct = 6'b000000;
        at_cycle("lwr_decode", V_DECODE);
        at_cycle("lwr_memadr", V_MEMADR);
        at_cycle("lwr_memread", V_MEMREAD);
        @(posedge clk);
        reset = 1'b1;
        #1 chk("lwr_memwb_reset", V_RST);
        at_cycle("lwr_reset2", V_RST);
        reset = 1'b0;
        #1 chk("lwr_fetch_after", V_FETCH);
        at_cycle("lwr_decode_after", V_DECODE);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
